b3_enc_case_sync: RTL and testbench

- Registered 16-to-4 binary encoder with enable, implemented as a full case decode of a one-hot input.
- Converts a one-hot 16-bit request vector into its 4-bit bit index.
- Flags inputs that are not one-hot.
- Sits between one-hot select/request logic and index-consuming datapaths; all outputs are registered, one-cycle latency.

---
 rtl/b3_enc_case_sync_if.sv | 25 ++
 rtl/b3_enc_case_sync.sv | 67 ++++++
 tb/tb_b3_enc_case_sync.sv | 136 +++++++++++++
 3 files changed

// File: rtl/b3_enc_case_sync_if.sv
// Encoder bus: enable/one-hot request in, registered index/valid/err out.
// master drives the request side, slave is the encoder.
interface b3_enc_case_sync_if;
  logic        enable;
  logic [15:0] binary;
  logic [3:0]  binary_out;
  logic        valid;
  logic        err;

  modport master (
    output enable,
    output binary,
    input  binary_out,
    input  valid,
    input  err
  );

  modport slave (
    input  enable,
    input  binary,
    output binary_out,
    output valid,
    output err
  );
endinterface

// File: rtl/b3_enc_case_sync.sv
// Registered 16-to-4 one-hot encoder with enable and non-one-hot flag.
// Define B3_ENC_CASE_PRIORITY_EN to encode multi-hot inputs to the top set bit.
module b3_enc_case_sync #(
  parameter logic [3:0] IDLE_CODE = 4'h0
) (
  input  logic           clk,
  input  logic           rst,
  b3_enc_case_sync_if.slave bus
);

  logic [3:0] code_n;
  logic       valid_n;
  logic       err_n;

  always_comb begin
    code_n  = IDLE_CODE;
    valid_n = 1'b0;
    err_n   = 1'b0;
    if (bus.enable) begin
      valid_n = 1'b1;
      case (bus.binary)
        16'h0001: code_n = 4'd0;
        16'h0002: code_n = 4'd1;
        16'h0004: code_n = 4'd2;
        16'h0008: code_n = 4'd3;
        16'h0010: code_n = 4'd4;
        16'h0020: code_n = 4'd5;
        16'h0040: code_n = 4'd6;
        16'h0080: code_n = 4'd7;
        16'h0100: code_n = 4'd8;
        16'h0200: code_n = 4'd9;
        16'h0400: code_n = 4'd10;
        16'h0800: code_n = 4'd11;
        16'h1000: code_n = 4'd12;
        16'h2000: code_n = 4'd13;
        16'h4000: code_n = 4'd14;
        16'h8000: code_n = 4'd15;
        default: begin
          err_n   = 1'b1;
          valid_n = 1'b0;
`ifdef B3_ENC_CASE_PRIORITY_EN
          // Multi-hot: last assignment wins, so the highest set bit is kept.
          for (int i = 0; i < 16; i++) begin
            if (bus.binary[i]) begin
              code_n  = 4'(i);
              valid_n = 1'b1;
            end
          end
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.binary_out <= IDLE_CODE;
      bus.valid      <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      bus.binary_out <= code_n;
      bus.valid      <= valid_n;
      bus.err        <= err_n;
    end
  end

endmodule

// File: tb/tb_b3_enc_case_sync.sv
// Directed plus random checks of the one-hot encoder, default and 4'hF idle code.
// Expected values come from a popcount/bit-index reference model.
module tb_b3_enc_case_sync;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  b3_enc_case_sync_if bus0 ();
  b3_enc_case_sync_if bus1 ();

  b3_enc_case_sync dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  b3_enc_case_sync #(.IDLE_CODE(4'hF)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic en, input logic [15:0] b,
                       input logic [3:0] idle, output logic [3:0] code,
                       output logic vld, output logic er);
    int n;
    int hi;
    n  = $countones(b);
    hi = 0;
    for (int i = 0; i < 16; i++)
      if (b[i]) hi = i;
    code = idle;
    vld  = 1'b0;
    er   = 1'b0;
    if (!r && en) begin
      if (n == 1) begin
        code = 4'(hi);
        vld  = 1'b1;
      end else begin
        er = 1'b1;
`ifdef B3_ENC_CASE_PRIORITY_EN
        if (n > 1) begin
          code = 4'(hi);
          vld  = 1'b1;
        end
`endif
      end
    end
  endtask

  task automatic step(input string tag, input logic r, input logic en,
                      input logic [15:0] b);
    logic [3:0] c0, c1;
    logic       v0, v1, e0, e1;
    rst          = r;
    bus0.enable  = en;
    bus0.binary  = b;
    bus1.enable  = en;
    bus1.binary  = b;
    model(r, en, b, 4'h0, c0, v0, e0);
    model(r, en, b, 4'hF, c1, v1, e1);
    @(posedge clk);
    #1;
    check({tag, ".code"},     bus0.binary_out, c0);
    check({tag, ".valid"},    {3'b0, bus0.valid}, {3'b0, v0});
    check({tag, ".err"},      {3'b0, bus0.err},   {3'b0, e0});
    check({tag, ".codeF"},    bus1.binary_out, c1);
    check({tag, ".validF"},   {3'b0, bus1.valid}, {3'b0, v1});
    check({tag, ".errF"},     {3'b0, bus1.err},   {3'b0, e1});
  endtask

  initial begin
    logic [15:0] b;
    logic        en;
    logic        r;

    step("rst0", 1'b1, 1'b1, 16'h0010);
    step("rst1", 1'b1, 1'b1, 16'h0010);
    step("rel",  1'b0, 1'b1, 16'h0010);

    for (int k = 0; k < 16; k++) begin
      b = 16'h0001 << k;
      step("walk", 1'b0, 1'b1, b);
    end

    step("en_hi",  1'b0, 1'b1, 16'h0400);
    step("dis0",   1'b0, 1'b0, 16'h0800);
    step("dis1",   1'b0, 1'b0, 16'h1000);
    step("dis2",   1'b0, 1'b0, 16'h2000);
    step("dis3",   1'b0, 1'b0, 16'h4000);
    step("dis4",   1'b0, 1'b0, 16'h8000);
    step("reen",   1'b0, 1'b1, 16'h4000);

    step("zero",   1'b0, 1'b1, 16'h0000);
    step("multi",  1'b0, 1'b1, 16'h0005);
    step("multi2", 1'b0, 1'b1, 16'hFFFF);
    step("multi3", 1'b0, 1'b1, 16'h8001);

    step("ms_a",   1'b0, 1'b1, 16'h0002);
    step("ms_rst", 1'b1, 1'b1, 16'h0100);
    step("ms_rel", 1'b0, 1'b1, 16'h0100);

    step("p_rst",  1'b1, 1'b0, 16'h0000);
    step("p_dis",  1'b0, 1'b0, 16'h0000);
    step("p_zero", 1'b0, 1'b1, 16'h0000);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(3, 0))
        0:       b = 16'h0;
        1:       b = 16'($urandom);
        default: b = 16'h0001 << $urandom_range(15, 0);
      endcase
      en = ($urandom_range(7, 0) != 0);
      r  = ($urandom_range(19, 0) == 0);
      step("rand", r, en, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
